// File: rtl/wait_state_monitor.sv
// Serial-in capture of the wait-state ready line: rebuilds the 8-bit wait pattern,
// counts wait samples, flags glitches/timeouts and tracks the largest wait count seen.
module wait_state_monitor #(
  parameter int unsigned TAIL_MAX = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       rdyIn,
  input  logic       ack,
  input  logic       maxClr,
  output logic [7:0] cap,
  output logic [4:0] waits,
  output logic       glitch,
  output logic       timeout,
  output logic       valid,
  output logic       overrun,
  output logic [4:0] maxWaits
);

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TAIL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               wglitch_q, wglitch_d;
  logic               seen_one_q, seen_one_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic [PAT_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]   waits_q, waits_d;
  logic               glitch_q, glitch_d;
  logic               timeout_q, timeout_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   maxw_q, maxw_d;

  logic               tail_last_c;
  logic               done_entry_c;
  logic               begin_cap_c;
  logic               tmo_c;
  logic [CNT_W-1:0]   max_base_c;

  assign tail_last_c  = (tail_cnt_q == CNT_W'(TAIL_MAX - 1));
  assign done_entry_c = (state_q != S_DONE) && (state_d == S_DONE);
  assign begin_cap_c  = (state_q != S_SHIFT) && (state_d == S_SHIFT);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == BIT_W'(PAT_W - 1)) state_d = rdyIn ? S_DONE : S_TAIL;
      S_TAIL:  if (rdyIn || tail_last_c) state_d = S_DONE;
      S_DONE:  if (ack) state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers, result load and sticky flags
  always_comb begin
    pat_d      = pat_q;
    wcnt_d     = wcnt_q;
    wglitch_d  = wglitch_q;
    seen_one_d = seen_one_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    cap_d      = cap_q;
    waits_d    = waits_q;
    glitch_d   = glitch_q;
    timeout_d  = timeout_q;
    valid_d    = valid_q;
    overrun_d  = maxClr ? 1'b0 : overrun_q;
    max_base_c = maxClr ? '0 : maxw_q;
    maxw_d     = max_base_c;
    tmo_c      = 1'b0;

    unique case (state_q)
      S_SHIFT: begin
        pat_d      = {pat_q[PAT_W-2:0], rdyIn};
        seen_one_d = seen_one_q | rdyIn;
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        tail_cnt_d = '0;
        if (!rdyIn) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (seen_one_q) wglitch_d = 1'b1;
        end
        if (start) overrun_d = 1'b1;
      end
      S_TAIL: begin
        if (!rdyIn) begin
          wcnt_d     = wcnt_q + CNT_W'(1);
          tail_cnt_d = tail_cnt_q + CNT_W'(1);
          tmo_c      = tail_last_c;
        end
        if (start) overrun_d = 1'b1;
      end
      S_DONE: begin
        if (ack)        valid_d   = 1'b0;
        else if (start) overrun_d = 1'b1;
      end
      default: ;
    endcase

    if (begin_cap_c) begin
      wcnt_d     = '0;
      wglitch_d  = 1'b0;
      seen_one_d = 1'b0;
      bit_cnt_d  = '0;
      tail_cnt_d = '0;
    end

    if (done_entry_c) begin
      cap_d     = pat_d;
      waits_d   = wcnt_d;
      glitch_d  = wglitch_d;
      timeout_d = tmo_c;
      valid_d   = 1'b1;
      if (wcnt_d > max_base_c) maxw_d = wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pat_q      <= '1;
      wcnt_q     <= '0;
      wglitch_q  <= 1'b0;
      seen_one_q <= 1'b0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      cap_q      <= 8'hFF;
      waits_q    <= '0;
      glitch_q   <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      maxw_q     <= '0;
    end else begin
      pat_q      <= pat_d;
      wcnt_q     <= wcnt_d;
      wglitch_q  <= wglitch_d;
      seen_one_q <= seen_one_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      cap_q      <= cap_d;
      waits_q    <= waits_d;
      glitch_q   <= glitch_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      maxw_q     <= maxw_d;
    end
  end

  assign cap      = cap_q;
  assign waits    = waits_q;
  assign glitch   = glitch_q;
  assign timeout  = timeout_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign maxWaits = maxw_q;

endmodule
